// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential add/sub/compare/multiply front-end for the 7-seg decoder.
// Define ALU_SEQ_KEY_SYNC_EN to pass key_n through a two-flop synchroniser.
module alu_seq_core #(
   parameter int MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  sw,
   input  logic        key_n,
   output logic [12:0] disp_word,
   output logic        busy,
   output logic        done,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_MUL  = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   state_t      state_q;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic [1:0]  op_q;
   logic [7:0]  acc_q;
   logic [7:0]  mcand_q;
   logic [3:0]  mplier_q;
   logic [2:0]  cnt_q;
   logic [12:0] disp_q;
   logic        busy_q;
   logic        done_q;

   logic        key_in;
   logic        key_prev_q;
   logic        step;

   logic [7:0]  acc_d;
   logic [7:0]  mcand_d;
   logic [3:0]  mplier_d;

`ifdef ALU_SEQ_KEY_SYNC_EN
   logic key_s1_q;
   logic key_s2_q;

   // two-flop synchroniser; idles at the released level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_q <= 1'b1;
         key_s2_q <= 1'b1;
      end else begin
         key_s1_q <= key_n;
         key_s2_q <= key_s1_q;
      end
   end

   assign key_in = key_s2_q;
`else
   assign key_in = key_n;
`endif

   // remember last key level so a held key yields a single step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_prev_q <= 1'b1;
      end else begin
         key_prev_q <= key_in;
      end
   end

   assign step = key_prev_q & ~key_in;

   // one shift-add iteration of the 4x4 multiply
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
   end

   // display word in decoder format {lt, gt, eq, minus, carry, value}
   function automatic logic [12:0] alu_f(
      input logic [1:0] op,
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [7:0] prod
   );
      logic [8:0]  sum;
      logic [12:0] r;
      sum = {1'b0, a} + {1'b0, b};
      r   = '0;
      unique case (op)
         2'd0: r = {4'b0000, sum};
         2'd1: r = (a >= b) ? {5'b00000, a - b}
                            : {4'b0001, 1'b0, b - a};
         2'd2: r = {a < b, a > b, a == b, 2'b00, a};
         2'd3: r = {5'b00000, prod};
      endcase
      return r;
   endfunction

   // sequencer: capture A, B, op; execute; hold result until next step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_A;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         disp_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_A: begin
               disp_q <= {5'b00000, sw};
               if (step) begin
                  a_q     <= sw;
                  state_q <= S_B;
               end
            end
            S_B: begin
               disp_q <= {5'b00000, sw};
               if (step) begin
                  b_q     <= sw;
                  state_q <= S_OP;
               end
            end
            S_OP: begin
               disp_q <= {11'b0, sw[1:0]};
               if (step) begin
                  op_q <= sw[1:0];
                  if (sw[1:0] == 2'd3) begin
                     acc_q    <= '0;
                     mcand_q  <= {4'b0000, a_q[3:0]};
                     mplier_q <= b_q[3:0];
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= S_MUL;
                  end else begin
                     disp_q  <= alu_f(sw[1:0], a_q, b_q, 8'h00);
                     done_q  <= 1'b1;
                     state_q <= S_SHOW;
                  end
               end
            end
            S_MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q + 3'd1;
               if (cnt_q == 3'(MUL_CYCLES - 1)) begin
                  disp_q  <= alu_f(op_q, a_q, b_q, acc_d);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (step) begin
                  state_q <= S_A;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_A;
            end
         endcase
      end
   end

   assign disp_word = disp_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed vectors; expected display words are queued
// at stimulus time and popped by a monitor whenever done pulses.
module tb_alu_seq_core;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_n = 1'b1;
   logic [7:0]  sw    = 8'h00;
   logic [12:0] disp_word;
   logic        busy;
   logic        done;
   logic [2:0]  state_dbg;

   int          tests = 0;
   int          fails = 0;
   logic [12:0] exp_q[$];
   logic        done_prev = 1'b0;

`ifdef ALU_SEQ_KEY_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   alu_seq_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sw        (sw),
      .key_n     (key_n),
      .disp_word (disp_word),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest queued result
   always @(negedge clk) begin
      if (rst_n && done) begin
         chk("done_gap", {31'b0, done_prev}, 32'd0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got %0h, want no result",
                     disp_word);
         end else begin
            chk("result", {19'b0, disp_word}, {19'b0, exp_q.pop_front()});
         end
      end
      done_prev = rst_n ? done : 1'b0;
   end

   // press and release; returns at the negedge where the step took effect
   task automatic press();
      @(negedge clk);
      key_n = 1'b0;
      @(negedge clk);
      key_n = 1'b1;
      repeat (SYNC_LAT) @(negedge clk);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [12:0] exp,
                         input string tag);
      int lat;
      sw = a;
      press();
      chk({tag, "_stB"}, state_dbg, 1);
      sw = b;
      press();
      chk({tag, "_stOP"}, state_dbg, 2);
      sw = {6'b0, op};
      exp_q.push_back(exp);
      press();
      if (op == 2'd3) chk({tag, "_busy"}, busy, 1);
      lat = 0;
      while (!done && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, (op == 2'd3) ? 4 : 0);
      chk({tag, "_stSHOW"}, state_dbg, 4);
      sw = ~a;
      repeat (3) @(negedge clk);
      chk({tag, "_hold"}, disp_word, exp);
      press();
      chk({tag, "_stA"}, state_dbg, 0);
      @(negedge clk);
      chk({tag, "_preview"}, disp_word, {5'b0, sw});
   endtask

   initial begin
      #1;
      chk("rst_disp", disp_word, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_state", state_dbg, 0);
      @(negedge clk);
      rst_n = 1'b1;

      sw = 8'h5A;
      repeat (2) @(negedge clk);
      chk("preview_A", disp_word, 13'h05A);

      run_op(8'hF0, 8'h20, 2'd0, 13'h110, "add_carry");
      run_op(8'hFF, 8'hFF, 2'd0, 13'h1FE, "add_max");
      run_op(8'h05, 8'h0C, 2'd1, 13'h207, "sub_neg");
      run_op(8'h0C, 8'h05, 2'd1, 13'h007, "sub_pos");
      run_op(8'h3A, 8'h3A, 2'd1, 13'h000, "sub_zero");
      run_op(8'h3A, 8'h3A, 2'd2, 13'h43A, "cmp_eq");
      run_op(8'h41, 8'h40, 2'd2, 13'h841, "cmp_gt");
      run_op(8'h01, 8'h02, 2'd2, 13'h1001, "cmp_lt");
      run_op(8'hAF, 8'h5F, 2'd3, 13'h0E1, "mul_max");

      // multiply with a key press dropped mid-run
      sw = 8'hFF;
      press();
      sw = 8'h3D;
      press();
      sw = 8'h03;
      exp_q.push_back(13'h0C3);
      press();
      chk("mul_b1", busy, 1);
      chk("mul_st", state_dbg, 3);
      @(negedge clk);
      chk("mul_b2", busy, 1);
      key_n = 1'b0;
      @(negedge clk);
      chk("mul_b3", busy, 1);
      key_n = 1'b1;
      @(negedge clk);
      chk("mul_b4", busy, 1);
      @(negedge clk);
      chk("mul_b5", busy, 0);
      chk("mul_done", done, 1);
      chk("mul_show", state_dbg, 4);
      repeat (4 + SYNC_LAT) @(negedge clk);
      chk("mul_drop", state_dbg, 4);
      chk("mul_hold", disp_word, 13'h0C3);
      press();
      chk("mul_back", state_dbg, 0);

      // key held for 50 cycles captures once
      sw = 8'h77;
      @(negedge clk);
      key_n = 1'b0;
      repeat (10) @(negedge clk);
      sw = 8'h11;
      repeat (40) @(negedge clk);
      chk("hold_st", state_dbg, 1);
      key_n = 1'b1;
      repeat (SYNC_LAT + 1) @(negedge clk);
      press();
      chk("hold_stOP", state_dbg, 2);
      sw = 8'h00;
      exp_q.push_back(13'h088);
      press();
      chk("hold_done", done, 1);
      chk("hold_show", state_dbg, 4);
      press();
      chk("hold_back", state_dbg, 0);

      // asynchronous reset in the middle of a multiply
      sw = 8'h09;
      press();
      sw = 8'h07;
      press();
      sw = 8'h03;
      press();
      @(negedge clk);
      chk("mrst_busy", busy, 1);
      chk("mrst_pre", disp_word, 13'h003);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_disp", disp_word, 0);
      chk("mrst_busy0", busy, 0);
      chk("mrst_state", state_dbg, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_preview", disp_word, 13'h003);
      chk("mrst_st", state_dbg, 0);

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
